// File: rtl/y86_pkg.sv
// Shared Y86 memory-stage definitions: instruction codes, status codes and
// the memory-stage FSM state encoding.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'd0;
   localparam logic [3:0] I_NOP    = 4'd1;
   localparam logic [3:0] I_RRMOVQ = 4'd2;
   localparam logic [3:0] I_IRMOVQ = 4'd3;
   localparam logic [3:0] I_RMMOVQ = 4'd4;
   localparam logic [3:0] I_MRMOVQ = 4'd5;
   localparam logic [3:0] I_OPQ    = 4'd6;
   localparam logic [3:0] I_JXX    = 4'd7;
   localparam logic [3:0] I_CALL   = 4'd8;
   localparam logic [3:0] I_RET    = 4'd9;
   localparam logic [3:0] I_PUSHQ  = 4'd10;
   localparam logic [3:0] I_POPQ   = 4'd11;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bundle between execute, the memory stage, data memory and writeback.
// Handshake: an instruction moves on a rising edge where in_valid && in_ready;
// out_valid is a one-cycle pulse with no backpressure.
interface mem_stage_if #(
   parameter int N = 64
) ();
   logic         in_valid;
   logic         in_ready;
   logic [3:0]   icode;
   logic [N-1:0] valE;
   logic [N-1:0] valA;
   logic [N-1:0] valP;
   logic [2:0]   stat_in;
   logic         mem_rd;
   logic         mem_wr;
   logic [N-1:0] mem_addr;
   logic [N-1:0] mem_wdata;
   logic         mem_ack;
   logic [N-1:0] mem_rdata;
   logic         out_valid;
   logic [N-1:0] valM;
   logic [2:0]   stat_out;
   logic [3:0]   icode_out;

   modport slave (
      input  in_valid, icode, valE, valA, valP, stat_in, mem_ack, mem_rdata,
      output in_ready, mem_rd, mem_wr, mem_addr, mem_wdata, out_valid, valM,
             stat_out, icode_out
   );

   modport master (
      output in_valid, icode, valE, valA, valP, stat_in, mem_ack, mem_rdata,
      input  in_ready, mem_rd, mem_wr, mem_addr, mem_wdata, out_valid, valM,
             stat_out, icode_out
   );
endinterface

// File: rtl/mem_decode.sv
// Combinational access decoder: which strobe an instruction needs, at which
// address, and what data a write carries.
module mem_decode
   import y86_pkg::*;
#(
   parameter int N = 64
) (
   input  logic [3:0]   icode,
   input  logic [N-1:0] valE,
   input  logic [N-1:0] valA,
   input  logic [N-1:0] valP,
   output logic         rd,
   output logic         wr,
   output logic [N-1:0] addr,
   output logic [N-1:0] wdata
);
   always_comb begin
      rd    = 1'b0;
      wr    = 1'b0;
      addr  = '0;
      wdata = '0;
      case (icode)
         I_MRMOVQ: begin
            rd   = 1'b1;
            addr = valE;
         end
         I_RMMOVQ, I_PUSHQ: begin
            wr    = 1'b1;
            addr  = valE;
            wdata = valA;
         end
         I_CALL: begin
            wr    = 1'b1;
            addr  = valE;
            wdata = valP;
         end
         I_POPQ, I_RET: begin
            rd   = 1'b1;
            addr = valA;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/mem_stage.sv
// Y86 memory stage: one instruction at a time, bounded wait on the data
// memory, and a sticky halt after any non-AOK result.
module mem_stage
   import y86_pkg::*;
#(
   parameter int           N         = 64,
   parameter logic [N-1:0] MEM_LIMIT = 64'h2000,
   parameter int           TIMEOUT   = 16
) (
   input  logic              clk,
   input  logic              reset,
   mem_stage_if.slave        bus,
   output state_t            dbg_state
);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_t       state;
   logic         halted;
   logic [CW-1:0] cnt;
   logic         dec_rd, dec_wr;
   logic [N-1:0] dec_addr, dec_wdata;
   logic         accept, is_access, in_range;
   logic [2:0]   early_stat;

   mem_decode #(.N(N)) u_decode (
      .icode (bus.icode),
      .valE  (bus.valE),
      .valA  (bus.valA),
      .valP  (bus.valP),
      .rd    (dec_rd),
      .wr    (dec_wr),
      .addr  (dec_addr),
      .wdata (dec_wdata)
   );

   assign bus.in_ready = (state == S_IDLE) && !halted;
   assign accept       = bus.in_valid && bus.in_ready;
   assign is_access    = dec_rd || dec_wr;
   assign in_range     = dec_addr < MEM_LIMIT;
   // Status for instructions that never reach the memory.
   assign early_stat   = (is_access && !in_range) ? STAT_ADR : bus.stat_in;
   assign dbg_state    = state;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= S_IDLE;
         halted        <= 1'b0;
         cnt           <= '0;
         bus.mem_rd    <= 1'b0;
         bus.mem_wr    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.out_valid <= 1'b0;
         bus.valM      <= '0;
         bus.stat_out  <= STAT_AOK;
         bus.icode_out <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  bus.icode_out <= bus.icode;
                  bus.mem_addr  <= dec_addr;
                  bus.mem_wdata <= dec_wdata;
                  bus.valM      <= '0;
                  cnt           <= '0;
                  if (is_access && bus.stat_in == STAT_AOK && in_range) begin
                     bus.mem_rd <= dec_rd;
                     bus.mem_wr <= dec_wr;
                     state      <= S_ACCESS;
                  end else begin
                     bus.stat_out  <= early_stat;
                     bus.out_valid <= 1'b1;
                     halted        <= (early_stat != STAT_AOK);
                     state         <= S_RESP;
                  end
               end
            end
            S_ACCESS: begin
               // An ack on the last allowed cycle still completes the access.
               if (bus.mem_ack) begin
                  bus.valM      <= bus.mem_rd ? bus.mem_rdata : '0;
                  bus.stat_out  <= STAT_AOK;
                  bus.mem_rd    <= 1'b0;
                  bus.mem_wr    <= 1'b0;
                  bus.out_valid <= 1'b1;
                  state         <= S_RESP;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  bus.valM      <= '0;
                  bus.stat_out  <= STAT_ADR;
                  bus.mem_rd    <= 1'b0;
                  bus.mem_wr    <= 1'b0;
                  bus.out_valid <= 1'b1;
                  halted        <= 1'b1;
                  state         <= S_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RESP: begin
               bus.out_valid <= 1'b0;
               state         <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
